// File: rtl/ex_forward_ctrl.sv
// ex_forward_ctrl: ID-stage forwarding select generator and load-use stall unit.
// Latency: fwd selects are registered, 1 cycle (ID inputs -> EX cycle); stall_o is combinational.
// Backpressure: stall_o holds PC and IF/ID for one cycle per load-use pair; flush_i overrides it.
//
// Ports:
//   clk_i, rst_i        clock, asynchronous active-low reset
//   id_valid_i          ID instruction is real (0 = bubble)
//   id_rs_i / id_rt_i   ID source registers (operand A / operand B)
//   id_rd_i             ID final destination register
//   id_regwrite_i       ID instruction writes the register file
//   id_memread_i        ID instruction is a load
//   flush_i             squash IF, ID and EX (taken branch resolved in MEM)
//   fwd_a_sel_o         EX operand-A mux select (00 RF, 01 MEM/WB, 10 EX/MEM)
//   fwd_b_sel_o         EX operand-B mux select, same encoding
//   stall_o             load-use stall request
module ex_forward_ctrl #(
  parameter int REG_AW = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              id_regwrite_i,
  input  logic              id_memread_i,
  input  logic              flush_i,
  output logic [1:0]        fwd_a_sel_o,
  output logic [1:0]        fwd_b_sel_o,
  output logic              stall_o
);

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_MWB = 2'b01;
  localparam logic [1:0] SEL_EXM = 2'b10;

  // Shadow of the instruction in EX.
  logic              ex_vld;
  logic              ex_rw;
  logic              ex_mr;
  logic [REG_AW-1:0] ex_rd;

  // Shadow of the instruction in MEM. Its memread flag is not kept: by the
  // time a load reaches MEM its data is forwardable, so only the producer
  // identity matters here.
  logic              mem_vld;
  logic              mem_rw;
  logic [REG_AW-1:0] mem_rd;

  // The WB stage needs no shadow at all: the register file is
  // write-before-read, so an instruction retiring from MEM is already
  // visible through the normal register read of the ID instruction.

  // Producer matches. Register 0 is hard-wired and never a dependency.
  logic rs_nonzero;
  logic rt_nonzero;
  logic ex_prod_a;
  logic ex_prod_b;
  logic mem_prod_a;
  logic mem_prod_b;

  assign rs_nonzero = (id_rs_i != '0);
  assign rt_nonzero = (id_rt_i != '0);

  assign ex_prod_a  = ex_vld  && ex_rw  && (ex_rd  == id_rs_i) && rs_nonzero;
  assign ex_prod_b  = ex_vld  && ex_rw  && (ex_rd  == id_rt_i) && rt_nonzero;
  assign mem_prod_a = mem_vld && mem_rw && (mem_rd == id_rs_i) && rs_nonzero;
  assign mem_prod_b = mem_vld && mem_rw && (mem_rd == id_rt_i) && rt_nonzero;

  // A load sitting in EX has no result yet on the EX/MEM bus, so a dependent
  // ID instruction must wait one cycle and pick the value up from MEM/WB.
  logic hazard;
  assign hazard  = id_valid_i && ex_mr && (ex_prod_a || ex_prod_b);
  assign stall_o = hazard && !flush_i;

  // Next-cycle selects. The EX producer is the most recent one, so it is
  // checked first; it will occupy EX/MEM when the ID instruction reaches EX.
  logic [1:0] nxt_a_sel;
  logic [1:0] nxt_b_sel;

  always_comb begin
    nxt_a_sel = SEL_RF;
    nxt_b_sel = SEL_RF;
    if (id_valid_i) begin
      if (ex_prod_a)       nxt_a_sel = SEL_EXM;
      else if (mem_prod_a) nxt_a_sel = SEL_MWB;
      if (ex_prod_b)       nxt_b_sel = SEL_EXM;
      else if (mem_prod_b) nxt_b_sel = SEL_MWB;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ex_vld      <= 1'b0;
      ex_rw       <= 1'b0;
      ex_mr       <= 1'b0;
      ex_rd       <= '0;
      mem_vld     <= 1'b0;
      mem_rw      <= 1'b0;
      mem_rd      <= '0;
      fwd_a_sel_o <= SEL_RF;
      fwd_b_sel_o <= SEL_RF;
    end else if (flush_i) begin
      // Squash the EX instruction (it would have moved to MEM) and the ID one.
      mem_vld     <= 1'b0;
      mem_rw      <= 1'b0;
      mem_rd      <= '0;
      ex_vld      <= 1'b0;
      ex_rw       <= 1'b0;
      ex_mr       <= 1'b0;
      ex_rd       <= '0;
      fwd_a_sel_o <= SEL_RF;
      fwd_b_sel_o <= SEL_RF;
    end else if (hazard) begin
      // Load advances; a bubble enters EX while ID is held for re-evaluation.
      mem_vld     <= ex_vld;
      mem_rw      <= ex_rw;
      mem_rd      <= ex_rd;
      ex_vld      <= 1'b0;
      ex_rw       <= 1'b0;
      ex_mr       <= 1'b0;
      ex_rd       <= '0;
      fwd_a_sel_o <= SEL_RF;
      fwd_b_sel_o <= SEL_RF;
    end else begin
      mem_vld     <= ex_vld;
      mem_rw      <= ex_rw;
      mem_rd      <= ex_rd;
      // Flags are qualified by valid so a bubble can never look like a producer.
      ex_vld      <= id_valid_i;
      ex_rw       <= id_valid_i && id_regwrite_i;
      ex_mr       <= id_valid_i && id_memread_i;
      ex_rd       <= id_valid_i ? id_rd_i : '0;
      fwd_a_sel_o <= nxt_a_sel;
      fwd_b_sel_o <= nxt_b_sel;
    end
  end

  // Selects never take the unused encoding.
  a_sel_legal: assert property (@(posedge clk_i) disable iff (!rst_i)
    (fwd_a_sel_o != 2'b11) && (fwd_b_sel_o != 2'b11));

  // A stall inserts a bubble into EX, so it can never repeat on the next cycle.
  a_stall_single: assert property (@(posedge clk_i) disable iff (!rst_i)
    stall_o |=> !stall_o);

endmodule

// File: tb/tb_ex_forward_ctrl.sv
// tb_ex_forward_ctrl: self-checking bench for ex_forward_ctrl.
// Expected selects are pushed to a scoreboard queue when an instruction is
// driven into ID and popped one edge later when it sits in EX.
module tb_ex_forward_ctrl;

  logic       clk = 1'b0;
  logic       rst_i;
  logic       id_valid_i;
  logic [4:0] id_rs_i;
  logic [4:0] id_rt_i;
  logic [4:0] id_rd_i;
  logic       id_regwrite_i;
  logic       id_memread_i;
  logic       flush_i;
  logic [1:0] fwd_a_sel_o;
  logic [1:0] fwd_b_sel_o;
  logic       stall_o;

  int n_chk  = 0;
  int n_pass = 0;
  logic [3:0] exp_q[$];
  logic [3:0] exp;

  ex_forward_ctrl #(.REG_AW(5)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .id_valid_i   (id_valid_i),
    .id_rs_i      (id_rs_i),
    .id_rt_i      (id_rt_i),
    .id_rd_i      (id_rd_i),
    .id_regwrite_i(id_regwrite_i),
    .id_memread_i (id_memread_i),
    .flush_i      (flush_i),
    .fwd_a_sel_o  (fwd_a_sel_o),
    .fwd_b_sel_o  (fwd_b_sel_o),
    .stall_o      (stall_o)
  );

  always #5 clk = ~clk;

  // Drive one ID instruction and record the selects it must see in EX.
  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic rw, input logic mr,
                       input logic fl, input logic [1:0] ea, input logic [1:0] eb);
    id_valid_i    = v;
    id_rs_i       = rs;
    id_rt_i       = rt;
    id_rd_i       = rd;
    id_regwrite_i = rw;
    id_memread_i  = mr;
    flush_i       = fl;
    exp_q.push_back({ea, eb});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Empty the pipeline with bubbles; nothing is scored here.
  task automatic drain();
    for (int i = 0; i < 3; i++) begin
      id_valid_i = 1'b0; id_rs_i = '0; id_rt_i = '0; id_rd_i = '0;
      id_regwrite_i = 1'b0; id_memread_i = 1'b0; flush_i = 1'b0;
      tick();
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      id_valid_i    = 1'b1;
      id_rs_i       = 5'($urandom_range(0, 31));
      id_rt_i       = 5'($urandom_range(0, 31));
      id_rd_i       = 5'($urandom_range(0, 31));
      id_regwrite_i = 1'b1;
      id_memread_i  = 1'($urandom_range(0, 1));
      flush_i       = 1'b0;
      #1;
      n_chk++;
      if (stall_o !== 1'b0) $display("FAIL reset_stall[%0d]: got %b want 0", i, stall_o);
      else n_pass++;
      tick();
      n_chk++;
      if ({fwd_a_sel_o, fwd_b_sel_o} !== 4'b0000)
        $display("FAIL reset_sel[%0d]: got %b want 0000", i, {fwd_a_sel_o, fwd_b_sel_o});
      else n_pass++;
    end
    rst_i = 1'b1;
    // First instruction after release: add $3,$1,$2 from empty slots.
    drive(1, 1, 2, 3, 1, 0, 0, 2'b00, 2'b00);
    #1;
    n_chk++;
    if (stall_o !== 1'b0) $display("FAIL reset_first_stall: got %b want 0", stall_o);
    else n_pass++;
    tick();
    exp = exp_q.pop_front();
    n_chk++;
    if ({fwd_a_sel_o, fwd_b_sel_o} !== exp)
      $display("FAIL reset_first_sel: got %b want %b", {fwd_a_sel_o, fwd_b_sel_o}, exp);
    else n_pass++;
  endtask

  task automatic test_ex_mem_fwd();
    drain();
    drive(1, 1, 2, 3, 1, 0, 0, 2'b00, 2'b00);  // add $3,$1,$2
    tick();
    exp = exp_q.pop_front();
    drive(1, 3, 5, 4, 1, 0, 0, 2'b10, 2'b00);  // sub $4,$3,$5
    #1;
    n_chk++;
    if (stall_o !== 1'b0) $display("FAIL exmem_stall: got %b want 0", stall_o);
    else n_pass++;
    tick();
    exp = exp_q.pop_front();
    n_chk++;
    if ({fwd_a_sel_o, fwd_b_sel_o} !== exp)
      $display("FAIL exmem_sel: got %b want %b", {fwd_a_sel_o, fwd_b_sel_o}, exp);
    else n_pass++;
  endtask

  task automatic test_mem_wb_fwd();
    // add $3 ; nop ; or $6,$7,$3 -> B from MEM/WB
    drain();
    drive(1, 1, 2, 3, 1, 0, 0, 2'b00, 2'b00); tick(); exp = exp_q.pop_front();
    drive(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00); tick(); exp = exp_q.pop_front();
    drive(1, 7, 3, 6, 1, 0, 0, 2'b00, 2'b01); tick(); exp = exp_q.pop_front();
    n_chk++;
    if ({fwd_a_sel_o, fwd_b_sel_o} !== exp)
      $display("FAIL memwb_sel: got %b want %b", {fwd_a_sel_o, fwd_b_sel_o}, exp);
    else n_pass++;

    // add $3 ; add $3 ; or $6,$3,$3 -> newest producer wins on both
    drain();
    drive(1, 1, 2, 3, 1, 0, 0, 2'b00, 2'b00); tick(); exp = exp_q.pop_front();
    drive(1, 8, 9, 3, 1, 0, 0, 2'b00, 2'b00); tick(); exp = exp_q.pop_front();
    drive(1, 3, 3, 6, 1, 0, 0, 2'b10, 2'b10); tick(); exp = exp_q.pop_front();
    n_chk++;
    if ({fwd_a_sel_o, fwd_b_sel_o} !== exp)
      $display("FAIL priority_sel: got %b want %b", {fwd_a_sel_o, fwd_b_sel_o}, exp);
    else n_pass++;

    // add $3 ; nop ; nop ; or $6,$3,$7 -> producer is in WB, read from RF
    drain();
    drive(1, 1, 2, 3, 1, 0, 0, 2'b00, 2'b00); tick(); exp = exp_q.pop_front();
    drive(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00); tick(); exp = exp_q.pop_front();
    drive(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00); tick(); exp = exp_q.pop_front();
    drive(1, 3, 7, 6, 1, 0, 0, 2'b00, 2'b00); tick(); exp = exp_q.pop_front();
    n_chk++;
    if ({fwd_a_sel_o, fwd_b_sel_o} !== exp)
      $display("FAIL wb_no_fwd_sel: got %b want %b", {fwd_a_sel_o, fwd_b_sel_o}, exp);
    else n_pass++;
  endtask

  task automatic test_load_use();
    drain();
    drive(1, 1, 0, 2, 1, 1, 0, 2'b00, 2'b00);  // lw $2,0($1)
    tick(); exp = exp_q.pop_front();
    drive(1, 2, 2, 4, 1, 0, 0, 2'b00, 2'b00);  // add $4,$2,$2 : stalled, bubble to EX
    #1;
    n_chk++;
    if (stall_o !== 1'b1) $display("FAIL lu_stall: got %b want 1", stall_o);
    else n_pass++;
    tick(); exp = exp_q.pop_front();
    n_chk++;
    if ({fwd_a_sel_o, fwd_b_sel_o} !== exp)
      $display("FAIL lu_bubble_sel: got %b want %b", {fwd_a_sel_o, fwd_b_sel_o}, exp);
    else n_pass++;
    drive(1, 2, 2, 4, 1, 0, 0, 2'b01, 2'b01);  // same add, re-evaluated
    #1;
    n_chk++;
    if (stall_o !== 1'b0) $display("FAIL lu_release: got %b want 0", stall_o);
    else n_pass++;
    tick(); exp = exp_q.pop_front();
    n_chk++;
    if ({fwd_a_sel_o, fwd_b_sel_o} !== exp)
      $display("FAIL lu_fwd_sel: got %b want %b", {fwd_a_sel_o, fwd_b_sel_o}, exp);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    // Continues from test_load_use: a second lw $2 then a second use stalls again.
    drive(1, 1, 0, 2, 1, 1, 0, 2'b00, 2'b00);
    #1;
    n_chk++;
    if (stall_o !== 1'b0) $display("FAIL b2b_lw_stall: got %b want 0", stall_o);
    else n_pass++;
    tick(); exp = exp_q.pop_front();
    n_chk++;
    if ({fwd_a_sel_o, fwd_b_sel_o} !== exp)
      $display("FAIL b2b_lw_sel: got %b want %b", {fwd_a_sel_o, fwd_b_sel_o}, exp);
    else n_pass++;
    drive(1, 5, 2, 4, 1, 0, 0, 2'b00, 2'b00);
    #1;
    n_chk++;
    if (stall_o !== 1'b1) $display("FAIL b2b_stall: got %b want 1", stall_o);
    else n_pass++;
    tick(); exp = exp_q.pop_front();
    drive(1, 5, 2, 4, 1, 0, 0, 2'b00, 2'b01);
    #1;
    n_chk++;
    if (stall_o !== 1'b0) $display("FAIL b2b_release: got %b want 0", stall_o);
    else n_pass++;
    tick(); exp = exp_q.pop_front();
    n_chk++;
    if ({fwd_a_sel_o, fwd_b_sel_o} !== exp)
      $display("FAIL b2b_fwd_sel: got %b want %b", {fwd_a_sel_o, fwd_b_sel_o}, exp);
    else n_pass++;
  endtask

  task automatic test_zero_bubble();
    drain();
    // Producer to $0, consumer of $0.
    drive(1, 1, 2, 0, 1, 0, 0, 2'b00, 2'b00); tick(); exp = exp_q.pop_front();
    drive(1, 0, 0, 5, 1, 0, 0, 2'b00, 2'b00); tick(); exp = exp_q.pop_front();
    n_chk++;
    if ({fwd_a_sel_o, fwd_b_sel_o} !== exp)
      $display("FAIL zero_sel: got %b want %b", {fwd_a_sel_o, fwd_b_sel_o}, exp);
    else n_pass++;
    // Invalid producer of $3 (id_valid_i=0), consumer of $3.
    drive(0, 1, 2, 3, 1, 0, 0, 2'b00, 2'b00); tick(); exp = exp_q.pop_front();
    drive(1, 3, 3, 7, 1, 0, 0, 2'b00, 2'b00); tick(); exp = exp_q.pop_front();
    n_chk++;
    if ({fwd_a_sel_o, fwd_b_sel_o} !== exp)
      $display("FAIL bubble_prod_sel: got %b want %b", {fwd_a_sel_o, fwd_b_sel_o}, exp);
    else n_pass++;
    // Non-writing producer with rd=$6, consumer of $6.
    drive(1, 1, 2, 6, 0, 0, 0, 2'b00, 2'b00); tick(); exp = exp_q.pop_front();
    drive(1, 6, 6, 8, 1, 0, 0, 2'b00, 2'b00); tick(); exp = exp_q.pop_front();
    n_chk++;
    if ({fwd_a_sel_o, fwd_b_sel_o} !== exp)
      $display("FAIL norw_prod_sel: got %b want %b", {fwd_a_sel_o, fwd_b_sel_o}, exp);
    else n_pass++;
    // Load to $0 followed by a use of $0: no stall.
    drive(1, 1, 0, 0, 1, 1, 0, 2'b00, 2'b00); tick(); exp = exp_q.pop_front();
    drive(1, 0, 0, 9, 1, 0, 0, 2'b00, 2'b00);
    #1;
    n_chk++;
    if (stall_o !== 1'b0) $display("FAIL zero_load_stall: got %b want 0", stall_o);
    else n_pass++;
    tick(); exp = exp_q.pop_front();
    n_chk++;
    if ({fwd_a_sel_o, fwd_b_sel_o} !== exp)
      $display("FAIL zero_load_sel: got %b want %b", {fwd_a_sel_o, fwd_b_sel_o}, exp);
    else n_pass++;
  endtask

  task automatic test_flush();
    drain();
    // Load in EX, dependent in ID, flush in the same cycle.
    drive(1, 1, 0, 2, 1, 1, 0, 2'b00, 2'b00); tick(); exp = exp_q.pop_front();
    drive(1, 2, 2, 4, 1, 0, 1, 2'b00, 2'b00);
    #1;
    n_chk++;
    if (stall_o !== 1'b0) $display("FAIL flush_stall: got %b want 0", stall_o);
    else n_pass++;
    tick(); exp = exp_q.pop_front();
    n_chk++;
    if ({fwd_a_sel_o, fwd_b_sel_o} !== exp)
      $display("FAIL flush_sel: got %b want %b", {fwd_a_sel_o, fwd_b_sel_o}, exp);
    else n_pass++;
    // Consumer of the squashed load's destination.
    drive(1, 2, 2, 9, 1, 0, 0, 2'b00, 2'b00);
    #1;
    n_chk++;
    if (stall_o !== 1'b0) $display("FAIL flush_after_stall: got %b want 0", stall_o);
    else n_pass++;
    tick(); exp = exp_q.pop_front();
    n_chk++;
    if ({fwd_a_sel_o, fwd_b_sel_o} !== exp)
      $display("FAIL flush_after_sel: got %b want %b", {fwd_a_sel_o, fwd_b_sel_o}, exp);
    else n_pass++;
    // ALU producer in EX squashed by a flush: not forwarded from MEM afterwards.
    drain();
    drive(1, 1, 2, 3, 1, 0, 0, 2'b00, 2'b00); tick(); exp = exp_q.pop_front();
    drive(1, 8, 9, 10, 1, 0, 1, 2'b00, 2'b00); tick(); exp = exp_q.pop_front();
    drive(1, 3, 10, 11, 1, 0, 0, 2'b00, 2'b00); tick(); exp = exp_q.pop_front();
    n_chk++;
    if ({fwd_a_sel_o, fwd_b_sel_o} !== exp)
      $display("FAIL flush_alu_sel: got %b want %b", {fwd_a_sel_o, fwd_b_sel_o}, exp);
    else n_pass++;
  endtask

  task automatic test_reset_midop();
    drain();
    drive(1, 1, 2, 3, 1, 0, 0, 2'b00, 2'b00); tick(); exp = exp_q.pop_front();
    drive(1, 3, 5, 4, 1, 0, 0, 2'b10, 2'b00); tick(); exp = exp_q.pop_front();
    n_chk++;
    if ({fwd_a_sel_o, fwd_b_sel_o} !== exp)
      $display("FAIL midrst_pre_sel: got %b want %b", {fwd_a_sel_o, fwd_b_sel_o}, exp);
    else n_pass++;
    // Asynchronous assertion between edges clears the selects at once.
    rst_i = 1'b0;
    #1;
    n_chk++;
    if ({fwd_a_sel_o, fwd_b_sel_o} !== 4'b0000)
      $display("FAIL midrst_async_sel: got %b want 0000", {fwd_a_sel_o, fwd_b_sel_o});
    else n_pass++;
    tick();
    rst_i = 1'b1;
    // Slots were emptied, so a consumer of $3/$4 reads the register file.
    drive(1, 3, 4, 7, 1, 0, 0, 2'b00, 2'b00); tick(); exp = exp_q.pop_front();
    n_chk++;
    if ({fwd_a_sel_o, fwd_b_sel_o} !== exp)
      $display("FAIL midrst_after_sel: got %b want %b", {fwd_a_sel_o, fwd_b_sel_o}, exp);
    else n_pass++;
  endtask

  initial begin
    rst_i = 1'b0; id_valid_i = 1'b0; id_rs_i = '0; id_rt_i = '0; id_rd_i = '0;
    id_regwrite_i = 1'b0; id_memread_i = 1'b0; flush_i = 1'b0;
    test_reset();
    test_ex_mem_fwd();
    test_mem_wb_fwd();
    test_load_use();
    test_back_to_back();
    test_zero_bubble();
    test_flush();
    test_reset_midop();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ex_forward_ctrl.md
# ex_forward_ctrl

Forwarding and load-use hazard controller for the 5-stage pipeline. It sits in the ID stage, directly upstream of the two EX-stage ALU operand 3-to-1 muxes, and drives their 2-bit select inputs. It keeps its own shadow of the destination registers held in the EX, MEM and WB stages. It computes registered forward selects that arrive aligned with each instruction's EX cycle, and it asserts a one-cycle stall on a load-use hazard.

## Interface

Parameters:
- REG_AW, 5, register-index width.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- id_valid_i  in  1  the instruction in ID is real (0 = bubble).
- id_rs_i  in  REG_AW  source register A of the ID instruction.
- id_rt_i  in  REG_AW  source register B of the ID instruction.
- id_rd_i  in  REG_AW  final destination register of the ID instruction (already muxed rt/rd).
- id_regwrite_i  in  1  the ID instruction writes the register file.
- id_memread_i  in  1  the ID instruction is a load.
- flush_i  in  1  a taken branch was resolved in MEM; squash the IF, ID and EX instructions.
- fwd_a_sel_o  out  2  select for the EX operand-A mux. Valid during the EX cycle of the instruction.
- fwd_b_sel_o  out  2  select for the EX operand-B mux, same encoding as fwd_a_sel_o.
- stall_o  out  1  combinational. Hold PC and IF/ID, and insert a bubble into ID/EX.

Select encoding: 2'b00 = register-file value; 2'b01 = MEM/WB result; 2'b10 = EX/MEM ALU result; 2'b11 is never driven.

## Operation

- Internal slots EX, MEM and WB. Each slot holds {valid, rd, regwrite, memread}. They mirror the instruction occupying that stage.
- A slot is a producer for register r when valid=1, regwrite=1, rd==r and r!=0.
- Load-use hazard, evaluated combinationally: id_valid_i=1 and the EX slot is a producing load for id_rs_i or id_rt_i. stall_o equals hazard AND NOT flush_i.
- Next-select computation for source s (rs→A, rt→B):
  - 10 if the EX slot produces s, since that instruction will sit in EX/MEM next cycle.
  - otherwise 01 if the MEM slot produces s, since that instruction will sit in MEM/WB next cycle.
  - otherwise 00.
  - Most-recent producer wins.
  - Register 0 always gives 00.
- The WB slot is never forwarded. The register file is write-before-read, so a WB-cycle write is visible to the ID read in the same cycle.
- Clock edge, normal (no stall, no flush):
  - WB←MEM, MEM←EX.
  - EX←ID fields, with valid=id_valid_i.
  - sel outputs ← next-select.
- Clock edge, stall:
  - WB←MEM, MEM←EX.
  - EX←bubble (valid=0).
  - sel outputs ← 00.
  - The ID instruction is re-evaluated next cycle. At that point the load is in the MEM slot and resolves to 01.
- Clock edge, flush (priority over stall):
  - WB←MEM.
  - MEM←bubble (squashed EX instruction).
  - EX←bubble.
  - sel outputs ← 00.
- A bubble in ID (id_valid_i=0) still advances the pipeline. It produces a bubble EX slot and sel 00.

## Timing

- Reset (rst_i low, asynchronous):
  - All slots valid=0, rd=0, regwrite=0, memread=0.
  - fwd_a_sel_o=fwd_b_sel_o=00.
  - stall_o=0, because slots are empty.
- Reset release mid-operation: the first edge with rst_i high behaves as a normal edge from empty slots.
- Select latency: 1 cycle. Inputs sampled in an instruction's ID cycle appear on the sel outputs during its EX cycle.
- stall_o has zero latency from the id_* inputs and the EX slot. It lasts exactly 1 cycle per load-use hazard, because the following edge moves the load to the MEM slot.
- Back-to-back loads into the same register: each load-use pair stalls once, independently.
- flush_i and a hazard in the same cycle: stall_o=0, and the flush behaviour applies.
- Sel outputs are registers. They must not glitch with ID inputs.

## Test plan

- Reset: hold rst_i=0 with arbitrary inputs, then release. Required: sel=00/00 and stall_o=0 throughout; the first instruction after release gets sel 00.
- EX/MEM forward: `add $3,$1,$2` followed by `sub $4,$3,$5`. Required: sub's EX cycle shows fwd_a_sel_o=10 and fwd_b_sel_o=00, with no stall.
- MEM/WB forward and priority:
  - `add $3`, nop, `or $6,$7,$3`. Required: fwd_b_sel_o=01.
  - `add $3`, `add $3`, `or $6,$3,$3`. Required: both selects =10.
- Load-use: `lw $2,0($1)` followed by `add $4,$2,$2`. Required:
  - stall_o=1 for one cycle, and the EX slot gets a bubble with sel 00.
  - Next cycle stall_o=0, and add's EX cycle shows fwd_a_sel_o=fwd_b_sel_o=01.
- $zero and bubbles:
  - A producer with rd=0 followed by a consumer of $0. Required: sel 00.
  - A producer with id_valid_i=0 or regwrite=0 matching a source. Required: sel 00.
  - A load to $0 followed by a use. Required: no stall.
- Flush: a load in EX with a dependent instruction in ID, and flush_i=1 in the same cycle. Required:
  - stall_o=0.
  - After the edge, the EX and MEM slots are bubbles and sel=00.
  - A following consumer of the squashed destination gets sel 00.
